imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Sequential inverse of the Val2 operand decode: takes a 32-bit constant and produces the 12-bit shift_operand field that the datapath would decode back to the same value.
- Data-processing mode searches for an 8-bit immediate plus 4-bit rotate. Memory mode checks for a 12-bit unsigned offset.
- Used by the instruction-patch/boot-loader unit that synthesises instructions in hardware.
- Testing one rotation per cycle keeps the logic small, at a cost of variable latency.

Parameters:
- MAX_ROT, 16, number of rotate candidates tried (rotate field values 0..MAX_ROT-1). Must be ≤16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- value  input  32  constant to encode; captured on accepted start.
- mem_access  input  1  1 = 12-bit offset mode, 0 = rotated-immediate mode; captured with value.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a result is ready.
- ok  output  1  1 = value encodable; valid from done, held until the next accepted start.
- shift_operand  output  12  encoding {rot[3:0], imm8[7:0]} or offset[11:0]; zero when ok=0; held like ok.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, ok=0, shift_operand=0, rot counter=0, captured value=0. Reset mid-search aborts immediately and produces no done.
- States: IDLE, SEARCH.
- IDLE:
  - start=1 at an edge captures value and mode, clears ok and shift_operand, sets rot counter to 0, sets busy=1.
  - Next state is SEARCH.
  - done=0 in every cycle except the pulse cycle.
- SEARCH, mem_access=1, single cycle:
  - If value[31:12]==0: ok=1, shift_operand=value[11:0].
  - Otherwise: ok=0, shift_operand=0.
  - done=1 and busy=0 after the first edge in SEARCH, then return to IDLE.
- SEARCH, mem_access=0:
  - Each edge computes cand = value rotated LEFT by 2*rot (32-bit rotate; rot=0 gives value unchanged).
  - If cand[31:8]==0: ok=1, shift_operand={rot, cand[7:0]}, done=1, busy=0, go to IDLE.
  - Else if rot==MAX_ROT-1: ok=0, shift_operand=0, done=1, busy=0, go to IDLE.
  - Else rot increments by 1.
- The smallest matching rot always wins, so encoding is canonical (value 0 gives rot=0, imm=0).
- Latency (start sampled at edge 0):
  - done is high after edge r+1 for a match at rot r.
  - done is high after edge MAX_ROT on failure.
  - done is high after edge 1 in mem mode.
- Back-to-back: busy is low in the done cycle, so start asserted in that cycle is accepted at the next edge. done then drops, and ok and shift_operand clear.
- start while busy=1 is ignored; value and mem_access changes are ignored after capture.
- Round-trip invariant: decoding shift_operand as an immediate (imm8 rotated right by 2*rot) equals value whenever ok=1.

Test Plan:
- value=0x000000FF, mode 0 -> done 1 cycle after start, ok=1, shift_operand=0x0FF.
- value=0xFF000000, mode 0 -> done 5 cycles after start, ok=1, shift_operand=0x4FF.
- value=0xF000000F, mode 0 -> done 3 cycles after start, ok=1, shift_operand=0x2FF. value=0x00000000 -> ok=1, shift_operand=0x000 after 1 cycle.
- value=0x00000102, mode 0 (odd rotation needed) -> done 16 cycles after start, ok=0, shift_operand=0.
- mode 1: value=0x00000ABC -> ok=1, shift_operand=0xABC after 1 cycle. value=0x00001000 -> ok=0.
- Control cases:
  - Start a failing search, pulse start again at cycle 3 -> second pulse ignored, one done.
  - Assert rst_n=0 at cycle 5 of a search -> busy, done, ok and shift_operand go 0 asynchronously, no done follows.
  - Restart 0xFF in the done cycle -> accepted, result 0x0FF.
- Random: 1000 random values in mode 0, including generated encodable ones -> round-trip invariant holds, canonical minimal rot, latency = rot+1.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Request/result bundle for the constant encoder: one request channel
// (start/value/mem_access) and one result channel (busy/done/ok/shift_operand).
interface imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        mem_access;
  logic        busy;
  logic        done;
  logic        ok;
  logic [11:0] shift_operand;

  modport slave (
    input  start, value, mem_access,
    output busy, done, ok, shift_operand
  );

  modport master (
    output start, value, mem_access,
    input  busy, done, ok, shift_operand
  );
endinterface

// File: rtl/imm_encoder.sv
// Sequential inverse of the Val2 operand decode. In rotated-immediate mode it
// tries one rotate amount per cycle, smallest first, so the first hit is the
// canonical encoding. In memory mode it checks for a 12-bit unsigned offset.
module imm_encoder #(
  parameter int unsigned MAX_ROT = 16  // rotate candidates tried, 1..16
) (
  input  logic clk,
  input  logic rst_n,
  imm_encoder_if.slave bus
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [3:0] LAST_ROT = 4'(MAX_ROT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_rot,   w_rot_nxt;
  logic [31:0] r_value, w_value_nxt;
  logic        r_mode,  w_mode_nxt;
  logic        r_busy,  w_busy_nxt;
  logic        r_done,  w_done_nxt;
  logic        r_ok,    w_ok_nxt;
  logic [11:0] r_so,    w_so_nxt;

  logic [4:0]  w_sh;
  logic [31:0] w_cand;

  // Candidate = captured value rotated left by 2*rot; a shift by 32 yields 0,
  // so rot=0 leaves the value unchanged.
  assign w_sh   = {r_rot, 1'b0};
  assign w_cand = (r_value << w_sh) | (r_value >> (6'd32 - {1'b0, w_sh}));

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.ok            = r_ok;
  assign bus.shift_operand = r_so;

  // State and datapath registers; reset aborts any search without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rot   <= '0;
      r_value <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_so    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rot   <= w_rot_nxt;
      r_value <= w_value_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ok    <= w_ok_nxt;
      r_so    <= w_so_nxt;
    end
  end

  // Next-state and result logic; done defaults low so it only ever pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_rot_nxt   = r_rot;
    w_value_nxt = r_value;
    w_mode_nxt  = r_mode;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ok_nxt    = r_ok;
    w_so_nxt    = r_so;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_value_nxt = bus.value;
          w_mode_nxt  = bus.mem_access;
          w_ok_nxt    = 1'b0;
          w_so_nxt    = '0;
          w_rot_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (r_mode) begin
          w_ok_nxt    = (r_value[31:12] == 20'd0);
          w_so_nxt    = (r_value[31:12] == 20'd0) ? r_value[11:0] : 12'd0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (w_cand[31:8] == 24'd0) begin
          w_ok_nxt    = 1'b1;
          w_so_nxt    = {r_rot, w_cand[7:0]};
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_rot == LAST_ROT) begin
          w_ok_nxt    = 1'b0;
          w_so_nxt    = '0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_rot_nxt   = r_rot + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
